// File: rtl/rom_image_plotter.sv
// Streams a WIDTH x HEIGHT image out of a synchronous-read ROM in raster order
// and presents it on the VGA adapter plot interface, one pixel per clock.
module rom_image_plotter #(
  parameter int         WIDTH      = 160,
  parameter int         HEIGHT     = 120,
  parameter bit         KEY_EN     = 1'b0,
  parameter logic [2:0] KEY_COLOUR = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [14:0] rom_addr,
  output logic        rom_wren,
  output logic [2:0]  rom_data,
  input  logic [2:0]  rom_q,
  output logic [7:0]  plot_x,
  output logic [6:0]  plot_y,
  output logic [2:0]  plot_colour,
  output logic        plot_en,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  plot_x_q, plot_x_d;
  logic [6:0]  plot_y_q, plot_y_d;
  logic        vld_q, vld_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
      plot_x_q <= '0;
      plot_y_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      addr_q   <= addr_d;
      plot_x_q <= plot_x_d;
      plot_y_q <= plot_y_d;
      vld_q    <= vld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    addr_d   = addr_q;
    plot_x_d = plot_x_q;
    plot_y_d = plot_y_q;
    vld_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      FETCH: begin
        // Coordinates of the address issued now line up with rom_q next cycle.
        vld_d    = 1'b1;
        plot_x_d = x_q;
        plot_y_d = y_q;
        addr_d   = addr_q + 15'd1;
        x_d      = x_q + 8'd1;
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            addr_d  = '0;
            state_d = DRAIN;
          end else begin
            y_d = y_q + 7'd1;
          end
        end
      end
      DRAIN:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rom_addr    = addr_q;
  assign rom_wren    = 1'b0;
  assign rom_data    = 3'b000;
  assign plot_x      = plot_x_q;
  assign plot_y      = plot_y_q;
  assign plot_colour = rom_q;
  assign plot_en     = vld_q & ~(KEY_EN & (rom_q == KEY_COLOUR));
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);

endmodule
